// File: rtl/draw_pkg.sv
// Shared types and helpers for the draw priority controller.
package draw_pkg;

    localparam int DEF_NUM_LAYERS = 4;
    localparam int LAYER_W        = $clog2(DEF_NUM_LAYERS);

    typedef logic [LAYER_W-1:0] layer_idx_t;

    // Slot k holds a layer index; slot 0 is the highest priority.
    typedef layer_idx_t [DEF_NUM_LAYERS-1:0] prio_order_t;

    typedef enum logic {
        FLASH_IDLE = 1'b0,
        FLASH_RUN  = 1'b1
    } flash_state_t;

    // True when every layer index appears exactly once in the order.
    function automatic logic is_permutation(input prio_order_t order);
        logic [DEF_NUM_LAYERS-1:0] seen;
        seen = '0;
        for (int unsigned k = 0; k < DEF_NUM_LAYERS; k++) begin
            seen[order[k]] = 1'b1;
        end
        return &seen;
    endfunction

    function automatic prio_order_t identity_order();
        prio_order_t order;
        for (int unsigned k = 0; k < DEF_NUM_LAYERS; k++) begin
            order[k] = layer_idx_t'(k);
        end
        return order;
    endfunction

endpackage

// File: rtl/layer_priority_select.sv
// Combinational one-hot selection of the highest-priority requesting layer.
module layer_priority_select
    import draw_pkg::*;
(
    input  prio_order_t                order,
    input  logic [DEF_NUM_LAYERS-1:0]  req,
    output logic [DEF_NUM_LAYERS-1:0]  grant
);

    logic found;

    // Walk slots from highest priority; the first requesting layer wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < DEF_NUM_LAYERS; k++) begin
            if (!found && req[order[k]]) begin
                grant[order[k]] = 1'b1;
                found           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_priority_ctrl.sv
// Layer arbitration with frame-synchronous priority reload and hit-flash blinking.
module draw_priority_ctrl
    import draw_pkg::*;
#(
    parameter int NUM_LAYERS   = DEF_NUM_LAYERS,
    parameter int FLASH_LAYER  = 0,
    parameter int FLASH_FRAMES = 32,
    parameter int BLINK_PERIOD = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   startOfFrame,
    input  logic [NUM_LAYERS-1:0]                  drawingRequest,
    input  logic                                   cfgValid,
    input  logic [NUM_LAYERS*$clog2(NUM_LAYERS)-1:0] cfgPriority,
    output logic                                   cfgReady,
    output logic                                   cfgError,
    input  logic                                   hitEvent,
    output logic [NUM_LAYERS-1:0]                  grant,
    output logic                                   grantValid,
    output logic                                   flashActive,
    output logic                                   flashVisible
);

    localparam int CW = $clog2(FLASH_FRAMES + 1);
    localparam logic [CW-1:0] FRAMES_END = CW'(FLASH_FRAMES);
    localparam logic [CW-1:0] BLINK_P    = CW'(BLINK_PERIOD);

    prio_order_t               active_order;
    prio_order_t               shadow_order;
    prio_order_t               cfg_order;
    logic                      shadow_full;
    logic                      cfg_accept;
    logic                      cfg_ok;
    logic [NUM_LAYERS-1:0]     masked_req;
    logic [NUM_LAYERS-1:0]     grant_next;

    flash_state_t              state, state_n;
    logic [CW-1:0]             flash_cnt, flash_cnt_n;
    logic                      flash_vis, flash_vis_n;

    assign cfg_order    = cfgPriority;
    assign cfgReady     = !shadow_full;
    assign cfg_accept   = cfgValid && cfgReady;
    assign cfg_ok       = is_permutation(cfg_order);
    assign grantValid   = |grant;
    assign flashActive  = (state == FLASH_RUN);
    assign flashVisible = flash_vis;

    // Hide the flashing layer's request while it is in a hidden half-period.
    always_comb begin
        masked_req = drawingRequest;
        if (!flash_vis) begin
            masked_req[FLASH_LAYER] = 1'b0;
        end
    end

    layer_priority_select u_select (
        .order (active_order),
        .req   (masked_req),
        .grant (grant_next)
    );

    // Config handshake, frame-boundary shadow apply and the grant register.
    // The apply tests the registered shadow_full, so a write landing on the
    // same startOfFrame waits for the following pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_order <= identity_order();
            shadow_order <= identity_order();
            shadow_full  <= 1'b0;
            cfgError     <= 1'b0;
            grant        <= '0;
        end else begin
            grant <= grant_next;
            if (startOfFrame && shadow_full) begin
                active_order <= shadow_order;
                shadow_full  <= 1'b0;
            end
            if (cfg_accept) begin
                if (cfg_ok) begin
                    shadow_order <= cfg_order;
                    shadow_full  <= 1'b1;
                    cfgError     <= 1'b0;
                end else begin
                    cfgError     <= 1'b1;
                end
            end
        end
    end

    // Flash FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FLASH_IDLE;
            flash_cnt <= '0;
            flash_vis <= 1'b1;
        end else begin
            state     <= state_n;
            flash_cnt <= flash_cnt_n;
            flash_vis <= flash_vis_n;
        end
    end

    // Flash FSM next state: hit restarts, frames count up, blink toggles.
    always_comb begin
        state_n     = state;
        flash_cnt_n = flash_cnt;
        flash_vis_n = flash_vis;
        if (hitEvent) begin
            state_n     = FLASH_RUN;
            flash_cnt_n = '0;
            flash_vis_n = 1'b0;
        end else if (state == FLASH_RUN && startOfFrame) begin
            flash_cnt_n = flash_cnt + CW'(1);
            if (flash_cnt_n == FRAMES_END) begin
                state_n     = FLASH_IDLE;
                flash_vis_n = 1'b1;
            end else if ((flash_cnt_n % BLINK_P) == '0) begin
                flash_vis_n = !flash_vis;
            end
        end
    end

endmodule

// File: tb/tb_draw_priority_ctrl.sv
// Self-checking bench for draw_priority_ctrl: vector table, directed corner
// sequences and randomized traffic against a frame-level reference model.
module tb_draw_priority_ctrl;

    localparam int NL     = 4;
    localparam int FL     = 0;
    localparam int FRAMES = 32;
    localparam int BLINK  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          startOfFrame = 1'b0;
    logic [NL-1:0] drawingRequest = '0;
    logic          cfgValid = 1'b0;
    logic [7:0]    cfgPriority = '0;
    logic          cfgReady;
    logic          cfgError;
    logic          hitEvent = 1'b0;
    logic [NL-1:0] grant;
    logic          grantValid;
    logic          flashActive;
    logic          flashVisible;

    int checks = 0;
    int errors = 0;

    draw_priority_ctrl #(
        .NUM_LAYERS   (NL),
        .FLASH_LAYER  (FL),
        .FLASH_FRAMES (FRAMES),
        .BLINK_PERIOD (BLINK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .drawingRequest (drawingRequest),
        .cfgValid       (cfgValid),
        .cfgPriority    (cfgPriority),
        .cfgReady       (cfgReady),
        .cfgError       (cfgError),
        .hitEvent       (hitEvent),
        .grant          (grant),
        .grantValid     (grantValid),
        .flashActive    (flashActive),
        .flashVisible   (flashVisible)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int         m_act[NL];
    int         m_sh[NL];
    bit         m_full;
    bit         m_err;
    bit         m_flash;
    int         m_cnt;      // frames since the last hit while flashing
    logic [3:0] m_grant;

    // Visible in odd-numbered blink half-periods since the hit.
    function automatic bit m_vis();
        return !m_flash || (((m_cnt / BLINK) % 2) == 1);
    endfunction

    task automatic model_step();
        logic [3:0] masked;
        logic [3:0] g;
        int         ord[NL];
        bit         accept;
        bit         apply;
        bit         perm;
        int         occ;
        if (reset) begin
            for (int k = 0; k < NL; k++) m_act[k] = k;
            m_full  = 0;
            m_err   = 0;
            m_flash = 0;
            m_cnt   = 0;
            m_grant = '0;
            return;
        end
        masked = drawingRequest;
        if (!m_vis()) masked[FL] = 1'b0;
        g = '0;
        for (int k = 0; k < NL; k++) begin
            if (masked[m_act[k]]) begin
                g[m_act[k]] = 1'b1;
                break;
            end
        end
        m_grant = g;
        accept = cfgValid && !m_full;
        apply  = startOfFrame && m_full;
        if (apply) begin
            m_act  = m_sh;
            m_full = 0;
        end
        if (accept) begin
            for (int k = 0; k < NL; k++) ord[k] = (cfgPriority >> (2 * k)) & 3;
            perm = 1;
            for (int l = 0; l < NL; l++) begin
                occ = 0;
                for (int k = 0; k < NL; k++) if (ord[k] == l) occ++;
                if (occ != 1) perm = 0;
            end
            if (perm) begin
                m_sh   = ord;
                m_full = 1;
                m_err  = 0;
            end else begin
                m_err = 1;
            end
        end
        if (hitEvent) begin
            m_flash = 1;
            m_cnt   = 0;
        end else if (m_flash && startOfFrame) begin
            m_cnt++;
            if (m_cnt == FRAMES) begin
                m_flash = 0;
                m_cnt   = 0;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("grant",        32'(grant),        32'(m_grant));
        chk("grantValid",   32'(grantValid),   32'(|m_grant));
        chk("cfgReady",     32'(cfgReady),     32'(!m_full));
        chk("cfgError",     32'(cfgError),     32'(m_err));
        chk("flashActive",  32'(flashActive),  32'(m_flash));
        chk("flashVisible", 32'(flashVisible), 32'(m_vis()));
    endtask

    // One clock: advance the model on the current inputs, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    function automatic logic [7:0] pack(input int s0, input int s1, input int s2, input int s3);
        logic [1:0] a, b, c, d;
        a = 2'(s0); b = 2'(s1); c = 2'(s2); d = 2'(s3);
        return {d, c, b, a};
    endfunction

    task automatic frame_pulse();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit exp_vis;
        bit exp_act;
        int cyc;

        // identity order: lowest layer index wins
        vecs[0] = '{4'b0000, 4'b0000};
        vecs[1] = '{4'b0001, 4'b0001};
        vecs[2] = '{4'b1010, 4'b0010};
        vecs[3] = '{4'b1100, 4'b0100};
        vecs[4] = '{4'b1000, 4'b1000};
        vecs[5] = '{4'b1111, 4'b0001};
        vecs[6] = '{4'b0110, 4'b0010};
        vecs[7] = '{4'b1101, 4'b0001};

        // reset state
        reset = 1'b1;
        tick();
        tick();
        chk("rst_grant",   32'(grant),        32'h0);
        chk("rst_ready",   32'(cfgReady),     32'h1);
        chk("rst_error",   32'(cfgError),     32'h0);
        chk("rst_active",  32'(flashActive),  32'h0);
        chk("rst_visible", 32'(flashVisible), 32'h1);
        reset = 1'b0;

        drawingRequest = 4'b1010;
        tick();
        chk("first_grant", 32'(grant), 32'h2);

        // vector table under identity order, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            drawingRequest = vecs[i].req;
            tick();
            chk($sformatf("vec%0d", i), 32'(grant), 32'(vecs[i].exp));
        end

        // reversed order written mid-frame, takes effect after startOfFrame
        drawingRequest = 4'b1010;
        cfgValid = 1'b1;
        cfgPriority = pack(3, 2, 1, 0);
        tick();
        cfgValid = 1'b0;
        chk("wr_ready_low", 32'(cfgReady), 32'h0);
        tick();
        tick();
        chk("pre_sof_grant", 32'(grant), 32'h2);
        chk("pre_sof_ready", 32'(cfgReady), 32'h0);
        frame_pulse();
        chk("sof_grant_old", 32'(grant), 32'h2);
        chk("sof_ready_back", 32'(cfgReady), 32'h1);
        tick();
        chk("new_order_grant", 32'(grant), 32'h8);

        // non-permutation rejected, active order unchanged
        cfgValid = 1'b1;
        cfgPriority = pack(0, 0, 1, 2);
        tick();
        cfgValid = 1'b0;
        chk("bad_error", 32'(cfgError), 32'h1);
        chk("bad_ready", 32'(cfgReady), 32'h1);
        frame_pulse();
        tick();
        chk("bad_keeps_order", 32'(grant), 32'h8);
        cfgValid = 1'b1;
        cfgPriority = pack(0, 1, 2, 3);
        tick();
        cfgValid = 1'b0;
        chk("good_clears_err", 32'(cfgError), 32'h0);
        frame_pulse();
        tick();
        chk("identity_back", 32'(grant), 32'h2);

        // write coinciding with startOfFrame waits for the next pulse
        cfgValid = 1'b1;
        startOfFrame = 1'b1;
        cfgPriority = pack(3, 2, 1, 0);
        tick();
        cfgValid = 1'b0;
        startOfFrame = 1'b0;
        tick();
        tick();
        chk("same_sof_not_applied", 32'(grant), 32'h2);
        frame_pulse();
        tick();
        chk("same_sof_next_frame", 32'(grant), 32'h8);

        // flash sequence on layer 0
        drawingRequest = 4'b0001;
        hitEvent = 1'b1;
        tick();
        hitEvent = 1'b0;
        tick();
        tick();
        chk("flash_f0_hidden", 32'(grant), 32'h0);
        chk("flash_f0_active", 32'(flashActive), 32'h1);
        for (int p = 1; p <= 34; p++) begin
            frame_pulse();
            tick();
            tick();
            exp_vis = (p >= FRAMES) || (((p / BLINK) % 2) == 1);
            exp_act = (p < FRAMES);
            chk($sformatf("flash_p%0d_grant", p), 32'(grant), exp_vis ? 32'h1 : 32'h0);
            chk($sformatf("flash_p%0d_active", p), 32'(flashActive), 32'(exp_act));
        end

        // restart at count 20 coinciding with startOfFrame
        hitEvent = 1'b1;
        tick();
        hitEvent = 1'b0;
        for (int p = 1; p <= 20; p++) begin
            frame_pulse();
            tick();
        end
        chk("cnt20_visible", 32'(flashVisible), 32'h1);
        hitEvent = 1'b1;
        startOfFrame = 1'b1;
        tick();
        hitEvent = 1'b0;
        startOfFrame = 1'b0;
        chk("restart_hidden", 32'(flashVisible), 32'h0);
        chk("restart_active", 32'(flashActive), 32'h1);
        for (int p = 1; p <= 32; p++) begin
            frame_pulse();
            tick();
            if (p == 31) chk("restart_p31_active", 32'(flashActive), 32'h1);
            if (p == 32) chk("restart_p32_idle", 32'(flashActive), 32'h0);
        end

        // reset mid-flash with a pending order discards everything
        hitEvent = 1'b1;
        tick();
        hitEvent = 1'b0;
        frame_pulse();
        tick();
        cfgValid = 1'b1;
        cfgPriority = pack(3, 0, 1, 2);
        tick();
        cfgValid = 1'b0;
        chk("pending_ready", 32'(cfgReady), 32'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_grant",   32'(grant),        32'h0);
        chk("midrst_gvalid",  32'(grantValid),   32'h0);
        chk("midrst_ready",   32'(cfgReady),     32'h1);
        chk("midrst_error",   32'(cfgError),     32'h0);
        chk("midrst_active",  32'(flashActive),  32'h0);
        chk("midrst_visible", 32'(flashVisible), 32'h1);
        drawingRequest = 4'b1010;
        frame_pulse();
        tick();
        chk("pending_dropped", 32'(grant), 32'h2);

        // randomized traffic against the model
        cyc = 0;
        for (int n = 0; n < 4000; n++) begin
            drawingRequest = 4'($urandom);
            startOfFrame   = (cyc == 0);
            cyc            = (cyc + 1) % 6;
            hitEvent       = ($urandom_range(0, 149) == 0);
            reset          = ($urandom_range(0, 799) == 0);
            cfgValid       = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 0) begin
                cfgPriority = 8'($urandom);
            end else begin
                int a[4];
                int j, t;
                for (int k = 0; k < 4; k++) a[k] = k;
                for (int k = 3; k > 0; k--) begin
                    j = $urandom_range(0, k);
                    t = a[k]; a[k] = a[j]; a[j] = t;
                end
                cfgPriority = pack(a[0], a[1], a[2], a[3]);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
